// File: rtl/expr_pkg.sv
// Shared float word type and default latency for the expr pipeline and its stream controller.
package expr_pkg;

    localparam int unsigned FLOAT_W      = 32;
    localparam int unsigned EXPR_LATENCY = 16;

    typedef logic [FLOAT_W-1:0] float_t;

    localparam float_t FLOAT_ONE  = 32'h3f80_0000;
    localparam float_t FLOAT_HALF = 32'h3f00_0000;

endpackage

// File: rtl/expr_sync_fifo.sv
// Synchronous FIFO with a one-cycle flush; the head word is read straight from the storage flops.
module expr_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // NOTE: storage is reset so the head reads zero out of reset rather than relying on empty_o masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // The credit scheme upstream must make this unreachable.
    assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o && !flush_i));

endmodule

// File: rtl/expr_stream_ctrl.sv
// Issue/retire controller for the fixed-latency expr pipeline with credit-based output FIFO.
// Optional statistics counters are built when EXPR_STREAM_STATS_EN is defined.
module expr_stream_ctrl
    import expr_pkg::*;
#(
    parameter int unsigned LATENCY   = EXPR_LATENCY,
    parameter int unsigned OUT_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [FLOAT_W-1:0] s_data,
    output logic [FLOAT_W-1:0] expr_x,
    input  logic [FLOAT_W-1:0] expr_result,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [FLOAT_W-1:0] m_data,
    output logic               busy
`ifdef EXPR_STREAM_STATS_EN
    ,
    output logic [31:0]        n_issued,
    output logic [31:0]        n_retired
`endif
);

    localparam int unsigned INF_W = $clog2(LATENCY + 1);
    localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int unsigned OCC_W = $clog2(LATENCY + OUT_DEPTH + 2);

    logic [LATENCY-1:0] token_q,    token_d;
    logic [INF_W-1:0]   inflight_q, inflight_d;
    logic               s_ready_q,  s_ready_d;
    float_t             expr_x_q,   expr_x_d;

    logic               issue;
    logic               retire;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [OCC_W-1:0]   occupancy;

    // Flush must block issue in its own cycle, so it gates the registered ready directly.
    assign s_ready   = s_ready_q && !flush;
    assign issue     = s_valid && s_ready;
    assign retire    = token_q[LATENCY-1];
    assign occupancy = OCC_W'(inflight_q) + OCC_W'(fifo_count) + OCC_W'(issue);

    // NOTE: every _d gets an unconditional value before any override, so no latch can be inferred.
    always_comb begin
        token_d    = (token_q << 1) | LATENCY'(issue);
        inflight_d = inflight_q + INF_W'(issue) - INF_W'(retire);
        expr_x_d   = issue ? s_data : expr_x_q;
        s_ready_d  = !flush && !fifo_full && (occupancy < OCC_W'(OUT_DEPTH));
        if (flush) begin
            token_d    = '0;
            inflight_d = '0;
        end
    end

    // NOTE: state registers take non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            token_q    <= '0;
            inflight_q <= '0;
            s_ready_q  <= 1'b0;
            expr_x_q   <= '0;
        end else begin
            token_q    <= token_d;
            inflight_q <= inflight_d;
            s_ready_q  <= s_ready_d;
            expr_x_q   <= expr_x_d;
        end
    end

    expr_sync_fifo #(
        .WIDTH (FLOAT_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (flush),
        .push_i  (retire),
        .wdata_i (expr_result),
        .pop_i   (m_ready),
        .rdata_o (m_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign expr_x  = expr_x_q;
    assign m_valid = !fifo_empty;
    assign busy    = (inflight_q != '0) || !fifo_empty;

`ifdef EXPR_STREAM_STATS_EN
    logic [31:0] n_issued_q;
    logic [31:0] n_retired_q;

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_issued_q  <= '0;
            n_retired_q <= '0;
        end else begin
            if (issue)             n_issued_q  <= n_issued_q + 32'd1;
            if (m_valid && m_ready) n_retired_q <= n_retired_q + 32'd1;
        end
    end

    assign n_issued  = n_issued_q;
    assign n_retired = n_retired_q;
`endif

endmodule
